// File: rtl/multichannel_pulse_generator.sv
// Multichannel ultrasound transmit pulse generator: one shared symbol pattern,
// per-channel start delays, periodic frames, continuous or burst operation.
module multichannel_pulse_generator #(
    parameter int N_CH    = 4,
    parameter int PAT_W   = 32,
    parameter int CNT_W   = 32,
    parameter int LEN_W   = 16,
    parameter int BURST_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [PAT_W-1:0]       pattern,
    input  logic [$clog2(PAT_W):0] pat_len,
    input  logic [CNT_W-1:0]       tx_period,
    input  logic [LEN_W-1:0]       pulse_len,
    input  logic [N_CH*LEN_W-1:0]  ch_delay,
    input  logic [N_CH-1:0]        ch_en,
    input  logic [BURST_W-1:0]     burst_count,
    output logic [N_CH-1:0]        wave,
    output logic                   tx_start,
    output logic                   busy,
    output logic                   done
);

    localparam int PL_W  = $clog2(PAT_W) + 1;
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } top_state_e;

    typedef enum logic [1:0] {
        CH_WAIT = 2'd0,
        CH_EMIT = 2'd1,
        CH_OFF  = 2'd2
    } ch_state_e;

    top_state_e            state_q, state_d;
    logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [BURST_W-1:0]    frames_done_q, frames_done_d;
    logic                  tx_start_q, tx_start_d;
    logic                  done_q, done_d;
    logic [N_CH-1:0]       wave_q, wave_d;
    logic                  frame_start;
    logic                  wrap;

    // Frame configuration, captured at every frame start
    logic [PAT_W-1:0]      pattern_q;
    logic [PL_W-1:0]       pat_len_q;
    logic [CNT_W-1:0]      period_q;
    logic [LEN_W-1:0]      pulse_len_q;
    logic [N_CH*LEN_W-1:0] ch_delay_q;
    logic [N_CH-1:0]       ch_en_q;
    logic [BURST_W-1:0]    burst_q;

    logic [PL_W-1:0]       pat_len_clamped;
    logic [CNT_W-1:0]      period_in;
    logic [N_CH-1:0]       emit;

    assign pat_len_clamped = (pat_len > PL_W'(PAT_W)) ? PL_W'(PAT_W) : pat_len;
    assign period_in       = (tx_period == '0) ? CNT_W'(1) : tx_period;
    assign wrap            = (frame_cnt_q == period_q);

    always_comb begin
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        frames_done_d = frames_done_q;
        tx_start_d    = 1'b0;
        done_d        = 1'b0;
        frame_start   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d       = S_RUN;
                    frame_cnt_d   = '0;
                    frames_done_d = '0;
                    frame_start   = 1'b1;
                    tx_start_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    frames_done_d = frames_done_q + BURST_W'(1);
                    frame_cnt_d   = '0;
                    // A frame that ends with enable low has nothing left to drain
                    if (!enable || (burst_q != '0 && frames_done_d == burst_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        frame_start = 1'b1;
                        tx_start_d  = 1'b1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    if (!enable) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (wrap) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frame_cnt_q   <= '0;
            frames_done_q <= '0;
            tx_start_q    <= 1'b0;
            done_q        <= 1'b0;
            wave_q        <= '0;
        end else begin
            state_q       <= state_d;
            frame_cnt_q   <= frame_cnt_d;
            frames_done_q <= frames_done_d;
            tx_start_q    <= tx_start_d;
            done_q        <= done_d;
            wave_q        <= wave_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= '0;
            pat_len_q   <= '0;
            period_q    <= CNT_W'(1);
            pulse_len_q <= '0;
            ch_delay_q  <= '0;
            ch_en_q     <= '0;
            burst_q     <= '0;
        end else if (frame_start) begin
            pattern_q   <= pattern;
            pat_len_q   <= pat_len_clamped;
            period_q    <= period_in;
            pulse_len_q <= pulse_len;
            ch_delay_q  <= ch_delay;
            ch_en_q     <= ch_en;
            burst_q     <= burst_count;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            ch_state_e         st_q, st_d;
            logic [LEN_W-1:0]  wait_q, wait_d;
            logic [LEN_W-1:0]  hold_q, hold_d;
            logic [IDX_W-1:0]  idx_q, idx_d;
            logic [LEN_W-1:0]  dly_in;
            logic [LEN_W-1:0]  dly_lat;

            assign dly_in  = ch_delay[gi*LEN_W +: LEN_W];
            assign dly_lat = ch_delay_q[gi*LEN_W +: LEN_W];

            // At a frame start the latched copies are not yet valid, so raw inputs decide the entry state
            always_comb begin
                st_d   = st_q;
                wait_d = wait_q;
                hold_d = hold_q;
                idx_d  = idx_q;
                if (frame_start) begin
                    wait_d = '0;
                    hold_d = '0;
                    idx_d  = '0;
                    if (pat_len == '0) begin
                        st_d = CH_OFF;
                    end else if (dly_in == '0) begin
                        st_d = CH_EMIT;
                    end else begin
                        st_d = CH_WAIT;
                    end
                end else if (state_d == S_IDLE) begin
                    st_d = CH_OFF;
                end else begin
                    case (st_q)
                        CH_WAIT: begin
                            if (wait_q == dly_lat - LEN_W'(1)) begin
                                st_d = CH_EMIT;
                            end else begin
                                wait_d = wait_q + LEN_W'(1);
                            end
                        end
                        CH_EMIT: begin
                            if (hold_q == pulse_len_q) begin
                                hold_d = '0;
                                if (PL_W'(idx_q) == pat_len_q - PL_W'(1)) begin
                                    st_d = CH_OFF;
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end else begin
                                hold_d = hold_q + LEN_W'(1);
                            end
                        end
                        default: begin
                            st_d = CH_OFF;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    st_q   <= CH_OFF;
                    wait_q <= '0;
                    hold_q <= '0;
                    idx_q  <= '0;
                end else begin
                    st_q   <= st_d;
                    wait_q <= wait_d;
                    hold_q <= hold_d;
                    idx_q  <= idx_d;
                end
            end

            assign emit[gi] = (st_q == CH_EMIT) && pattern_q[idx_q];
        end
    endgenerate

    // Gate on the next top state so the output reads zero in every IDLE cycle
    assign wave_d = emit & ch_en_q & {N_CH{pat_len_q != '0}} & {N_CH{state_d != S_IDLE}};

    assign wave     = wave_q;
    assign tx_start = tx_start_q;
    assign done     = done_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_multichannel_pulse_generator.sv
// Scoreboard bench: each scenario plans its expected output timeline, pushes the
// resulting output events into a queue, and a monitor pops/compares as they appear.
module tb_multichannel_pulse_generator;

    localparam int TL = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] pattern;
    logic [5:0]  pat_len;
    logic [31:0] tx_period;
    logic [15:0] pulse_len;
    logic [63:0] ch_delay;
    logic [3:0]  ch_en;
    logic [15:0] burst_count;
    logic [3:0]  wave;
    logic        tx_start;
    logic        busy;
    logic        done;

    multichannel_pulse_generator dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .tx_period   (tx_period),
        .pulse_len   (pulse_len),
        .ch_delay    (ch_delay),
        .ch_en       (ch_en),
        .burst_count (burst_count),
        .wave        (wave),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        logic [6:0] val;   // {wave, tx_start, done, busy}
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_on = 1'b0;

    logic [3:0] tl_w  [TL];
    bit         tl_ts [TL];
    bit         tl_dn [TL];
    bit         tl_bz [TL];

    logic [31:0] m_pat;
    int          m_len;
    int          m_pl;
    int          m_dly [4];
    logic [3:0]  m_en;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Expected outputs of one frame starting at cycle f with frame length p+1
    task automatic plan_frame(input int f, input int p, input bit last);
        int t;
        tl_ts[f] = 1'b1;
        for (int i = f; i <= f + p; i++) tl_bz[i] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (m_en[c] && m_len > 0) begin
                for (int k = 0; k < m_len; k++) begin
                    for (int j = 0; j <= m_pl; j++) begin
                        t = f + 1 + m_dly[c] + k * (m_pl + 1) + j;
                        if (t <= f + p + 1) tl_w[t][c] = m_pat[k];
                    end
                end
            end
        end
        if (last) begin
            tl_dn[f + p + 1] = 1'b1;
            tl_w[f + p + 1]  = 4'h0;
        end
    endtask

    task automatic clear_from(input int r, input int e);
        for (int t = r; t <= e; t++) begin
            tl_w[t]  = 4'h0;
            tl_ts[t] = 1'b0;
            tl_dn[t] = 1'b0;
            tl_bz[t] = 1'b0;
        end
    endtask

    task automatic push_range(input int s, input int e);
        logic [6:0] v;
        logic [6:0] pv;
        for (int t = s; t <= e; t++) begin
            v  = {tl_w[t], tl_ts[t], tl_dn[t], tl_bz[t]};
            pv = {tl_w[t-1], tl_ts[t-1], tl_dn[t-1], tl_bz[t-1]};
            if (v != pv || tl_ts[t] || tl_dn[t]) q.push_back('{cyc: t, val: v});
        end
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cfg_a();
        pattern     = 32'hF05A;
        pat_len     = 6'd13;
        pulse_len   = 16'd9;
        tx_period   = 32'd199;
        ch_delay    = {16'd30, 16'd20, 16'd10, 16'd0};
        ch_en       = 4'hF;
        burst_count = 16'd0;
        m_pat       = 32'hF05A;
        m_len       = 13;
        m_pl        = 9;
        m_dly       = '{0, 10, 20, 30};
        m_en        = 4'hF;
    endtask

    // Monitor: one transaction per cycle where any output changes or a strobe fires
    initial begin
        logic [6:0] obs;
        logic [6:0] prev;
        ev_t        e;
        prev = 7'h0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                obs = {wave, tx_start, done, busy};
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event: nothing seen, required cycle %0d val=%b", e.cyc, e.val);
                end
                if (obs !== prev || tx_start || done) begin
                    $display("txn cycle=%0d wave=%b tx_start=%b done=%b busy=%b",
                             cyc, wave, tx_start, done, busy);
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event: cycle %0d got val=%b, required none", cyc, obs);
                    end else begin
                        e = q.pop_front();
                        if (e.cyc != cyc || e.val !== obs) begin
                            errors++;
                            $display("FAIL event: got cycle %0d val=%b, required cycle %0d val=%b",
                                     cyc, obs, e.cyc, e.val);
                        end
                    end
                end
                prev = obs;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f;
        int f2;
        for (int t = 0; t < TL; t++) begin
            tl_w[t]  = 4'h0;
            tl_ts[t] = 1'b0;
            tl_dn[t] = 1'b0;
            tl_bz[t] = 1'b0;
        end
        rst    = 1'b1;
        enable = 1'b0;
        cfg_a();
        repeat (3) @(negedge clk);
        chk("reset_wave", 32'(wave), 32'h0);
        chk("reset_tx_start", 32'(tx_start), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst    = 1'b0;
        mon_on = 1'b1;

        // Continuous run, mid-frame config change, then drain in frame 2
        f = cyc + 2;
        plan_frame(f, 199, 1'b0);
        plan_frame(f + 200, 199, 1'b0);
        m_pat = 32'h1;
        m_en  = 4'h1;
        plan_frame(f + 400, 199, 1'b1);
        push_range(f, f + 603);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 250);
        pattern = 32'h1;
        ch_en   = 4'h1;
        wait_cycle(f + 500);
        enable = 1'b0;
        wait_cycle(f + 605);
        cfg_a();

        // Burst of 3 frames
        burst_count = 16'd3;
        f = cyc + 2;
        plan_frame(f, 199, 1'b0);
        plan_frame(f + 200, 199, 1'b0);
        plan_frame(f + 400, 199, 1'b1);
        push_range(f, f + 603);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 600);
        enable = 1'b0;
        wait_cycle(f + 605);
        cfg_a();

        // Channel 3 truncated at the frame wrap, restarting identically
        pattern    = 32'hF05B;
        ch_delay   = {16'd190, 16'd20, 16'd10, 16'd0};
        m_pat      = 32'hF05B;
        m_dly[3]   = 190;
        f = cyc + 2;
        plan_frame(f, 199, 1'b0);
        plan_frame(f + 200, 199, 1'b1);
        push_range(f, f + 403);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 250);
        enable = 1'b0;
        wait_cycle(f + 405);
        cfg_a();

        // Reset pulse mid-emission with enable held high
        f  = cyc + 2;
        f2 = f + 17;
        plan_frame(f, 199, 1'b0);
        clear_from(f + 16, f + 300);
        plan_frame(f2, 199, 1'b1);
        push_range(f, f2 + 203);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 15);
        rst = 1'b1;
        wait_cycle(f + 16);
        chk("post_rst_wave", 32'(wave), 32'h0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        wait_cycle(f2 + 100);
        enable = 1'b0;
        wait_cycle(f2 + 205);

        // pat_len above PAT_W clamps to 32; single-frame burst, channels 1 and 3 only
        pattern     = 32'h8000_0001;
        pat_len     = 6'd40;
        pulse_len   = 16'd0;
        ch_delay    = {16'd3, 16'd2, 16'd1, 16'd0};
        ch_en       = 4'b1010;
        tx_period   = 32'd39;
        burst_count = 16'd1;
        m_pat = 32'h8000_0001;
        m_len = 32;
        m_pl  = 0;
        m_dly = '{0, 1, 2, 3};
        m_en  = 4'b1010;
        f = cyc + 2;
        plan_frame(f, 39, 1'b1);
        push_range(f, f + 43);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 40);
        enable = 1'b0;
        wait_cycle(f + 45);
        cfg_a();

        // pat_len=0 is silent, tx_period=0 acts as 1, burst of 2
        pat_len     = 6'd0;
        tx_period   = 32'd0;
        burst_count = 16'd2;
        m_len = 0;
        f = cyc + 2;
        plan_frame(f, 1, 1'b0);
        plan_frame(f + 2, 1, 1'b1);
        push_range(f, f + 7);
        wait_cycle(f - 1);
        enable = 1'b1;
        wait_cycle(f + 4);
        enable = 1'b0;
        wait_cycle(f + 10);

        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
